// File: rtl/branch_predict_unit_pkg.sv
// -----------------------------------------------------------------------------
// BranchUnitFuncts : shared types for the branch resolve / predict unit.
//   Type           - branch unit function select (conditional branches, jumps)
//   BhtCounter     - one 2-bit saturating direction counter
//   BHT_RESET      - reset state of every counter (weak not-taken)
//   is_conditional - true for the six compare-based branches
// -----------------------------------------------------------------------------
package BranchUnitFuncts;

  typedef enum logic [3:0] {
    BEQ  = 4'd0,
    BNE  = 4'd1,
    BLT  = 4'd2,
    BLTU = 4'd3,
    BGE  = 4'd4,
    BGEU = 4'd5,
    JAL  = 4'd6,
    JALR = 4'd7
  } Type;

  typedef logic [1:0] BhtCounter;

  localparam BhtCounter BHT_RESET = 2'b01;

  function automatic logic is_conditional(input Type funct);
    logic cond;
    case (funct)
      BEQ, BNE, BLT, BLTU, BGE, BGEU: cond = 1'b1;
      default:                        cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// -----------------------------------------------------------------------------
// sat_counter2 : one 2-bit saturating direction counter of the BHT.
//   clk    in  core clock
//   reset  in  synchronous active-high reset, loads BHT_RESET
//   update in  train this counter on the coming edge
//   taken  in  training direction (1 = count up, 0 = count down)
//   count  out current counter state (MSB is the prediction)
// -----------------------------------------------------------------------------
module sat_counter2
  import BranchUnitFuncts::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      update,
  input  logic      taken,
  output BhtCounter count
);

  BhtCounter count_r;

  // Saturation lives only here: 11 never wraps up, 00 never wraps down.
  function automatic BhtCounter sat_next(input BhtCounter cur, input logic up);
    BhtCounter nxt;
    if (up) begin
      if (cur == 2'b11) nxt = 2'b11;
      else              nxt = cur + 2'b01;
    end else begin
      if (cur == 2'b00) nxt = 2'b00;
      else              nxt = cur - 2'b01;
    end
    return nxt;
  endfunction

  // Counter state register with reset to weak not-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= BHT_RESET;
    end else if (update) begin
      count_r <= sat_next(count_r, taken);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit : branch resolver plus PC-indexed 2-bit BHT predictor.
//   clk, reset        core clock, synchronous active-high reset
//   lookup_pc         fetch PC; lookup_taken is its predicted direction (comb)
//   en, funct, op1,   resolve port; token is the actual outcome (comb) and
//   op2, pc,          mispredict flags token != pred_taken (comb)
//   pred_taken
// Optional build macro BRANCH_PERF_CNT_EN adds perf_branches and
// perf_mispredicts (32-bit wrapping event counters, cleared by reset).
// -----------------------------------------------------------------------------
module branch_predict_unit
  import BranchUnitFuncts::*;
#(
  parameter  int XLEN      = 32,
  parameter  int BHT_DEPTH = 64,
  localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  input  logic            en,
  input  Type             funct,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] pc,
  input  logic            pred_taken,
  output logic            token,
  output logic            mispredict
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  logic             token_s;
  logic             mispredict_s;
  logic             update_s;
  logic [IDX_W-1:0] res_idx_s;
  logic [IDX_W-1:0] lookup_idx_s;
  BhtCounter        bht_s [BHT_DEPTH];
  logic             unused_pc_bits_s;

  // Actual branch outcome; nothing resolves as taken without en
  always_comb begin
    token_s = 1'b0;
    if (en) begin
      case (funct)
        BEQ:       token_s = (op1 == op2);
        BNE:       token_s = (op1 != op2);
        BLT:       token_s = ($signed(op1) <  $signed(op2));
        BGE:       token_s = ($signed(op1) >= $signed(op2));
        BLTU:      token_s = (op1 <  op2);
        BGEU:      token_s = (op1 >= op2);
        JAL, JALR: token_s = 1'b1;
        default:   token_s = 1'b0;
      endcase
    end else begin
      token_s = 1'b0;
    end
  end

  assign mispredict_s = en & (token_s ^ pred_taken);
  assign token        = token_s;
  assign mispredict   = mispredict_s;

  // Word-aligned index: the two low PC bits never select a counter.
  assign res_idx_s    = pc[IDX_W+1:2];
  assign lookup_idx_s = lookup_pc[IDX_W+1:2];

  // Only the bits between [IDX_W+1:2] matter; fold the rest into a sink.
  assign unused_pc_bits_s = ^{lookup_pc, pc};

  // Jumps never train; reset also blocks training in the same cycle.
  assign update_s = en & is_conditional(funct) & ~reset;

  for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
    sat_counter2 u_ctr (
      .clk    (clk),
      .reset  (reset),
      .update (update_s && (res_idx_s == IDX_W'(g))),
      .taken  (token_s),
      .count  (bht_s[g])
    );
  end

  // No write-to-read bypass: a same-cycle update becomes visible next cycle.
  assign lookup_taken = reset ? 1'b0 : bht_s[lookup_idx_s][1];

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branches_r;
  logic [31:0] perf_mispredicts_r;

  // Event counters for conditional resolves and mispredictions
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches_r    <= 32'd0;
      perf_mispredicts_r <= 32'd0;
    end else begin
      if (en && is_conditional(funct)) perf_branches_r <= perf_branches_r + 32'd1;
      else                             perf_branches_r <= perf_branches_r;
      if (mispredict_s) perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
      else              perf_mispredicts_r <= perf_mispredicts_r;
    end
  end

  assign perf_branches    = perf_branches_r;
  assign perf_mispredicts = perf_mispredicts_r;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit : directed scenarios plus randomized resolves, all
// compared against a behavioural model of the BHT (integer counters clamped
// to 0..3) and of the branch rules.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;
  import BranchUnitFuncts::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;

  logic            clk;
  logic            reset;
  logic [XLEN-1:0] lookup_pc;
  logic            lookup_taken;
  logic            en;
  Type             funct;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic            token;
  logic            mispredict;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;
`endif

  branch_predict_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_pc    (lookup_pc),
    .lookup_taken (lookup_taken),
    .en           (en),
    .funct        (funct),
    .op1          (op1),
    .op2          (op2),
    .pc           (pc),
    .pred_taken   (pred_taken),
    .token        (token),
    .mispredict   (mispredict)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_compared;
  int          n_mismatched;
  int          bht_m [DEPTH];
  int unsigned exp_branches;
  int unsigned exp_mispred;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_cond(input Type f);
    return (f == BEQ) || (f == BNE) || (f == BLT) || (f == BLTU) ||
           (f == BGE) || (f == BGEU);
  endfunction

  function automatic bit m_token(input bit e, input Type f, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    int unsigned ua, ub;
    sa = a; sb = b; ua = a; ub = b;
    if (!e) return 1'b0;
    if (f == BEQ)  return ua == ub;
    if (f == BNE)  return ua != ub;
    if (f == BLT)  return sa <  sb;
    if (f == BGE)  return sa >= sb;
    if (f == BLTU) return ua <  ub;
    if (f == BGEU) return ua >= ub;
    if (f == JAL || f == JALR) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
    exp_branches = 0;
    exp_mispred  = 0;
  endtask

  // Apply inputs, let them settle, compare every output against the model.
  task automatic drive(input bit r, input bit e, input Type f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input bit pt,
                       input logic [31:0] lpc);
    bit t;
    reset = r; en = e; funct = f; op1 = a; op2 = b; pc = p; pred_taken = pt; lookup_pc = lpc;
    #2;
    t = m_token(e, f, a, b);
    check("token", 32'(token), 32'(t));
    check("mispredict", 32'(mispredict), 32'(e & (t ^ pt)));
    check("lookup_taken", 32'(lookup_taken), r ? 32'd0 : 32'(bht_m[m_idx(lpc)] >= 2));
`ifdef BRANCH_PERF_CNT_EN
    check("perf_branches", perf_branches, exp_branches);
    check("perf_mispredicts", perf_mispredicts, exp_mispred);
`endif
  endtask

  // Clock edge: advance the model with what the inputs imply.
  task automatic tick();
    bit t;
    @(posedge clk);
    t = m_token(en, funct, op1, op2);
    if (reset) begin
      model_reset();
    end else begin
      if (en && m_cond(funct)) begin
        int k;
        k = m_idx(pc);
        if (t) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
        else   bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
        exp_branches++;
      end
      if (en && (t != pred_taken)) exp_mispred++;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    drive(1'b0, 1'b0, BEQ, 32'd0, 32'd0, 32'd0, 1'b0, lpc);
    tick();
  endtask

  task automatic peek(input string tag, input logic [31:0] lpc, input bit exp);
    lookup_pc = lpc;
    #1;
    check(tag, 32'(lookup_taken), 32'(exp));
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, BEQ, 32'd0, 32'd0, 32'd0, 1'b0, 32'h100);
    tick();
  endtask

  initial begin
    Type         rf;
    logic [31:0] ra, rb;
    n_compared   = 0;
    n_mismatched = 0;
    model_reset();
    reset = 1'b1; en = 1'b0; funct = BEQ; op1 = '0; op2 = '0; pc = '0;
    pred_taken = 1'b0; lookup_pc = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state: every entry predicts not-taken
    reset = 1'b0;
    peek("reset_lookup_100", 32'h100, 1'b0);
    for (int i = 0; i < DEPTH; i++) peek("reset_entry", 32'(i * 4), 1'b0);

    // First taken BEQ mispredicts and moves the counter to weak taken
    drive(1'b0, 1'b1, BEQ, 32'd5, 32'd5, 32'h100, 1'b0, 32'h100);
    check("beq_token", 32'(token), 32'd1);
    check("beq_mispredict", 32'(mispredict), 32'd1);
    tick();
    peek("after_beq_100", 32'h100, 1'b1);
    peek("after_beq_104", 32'h104, 1'b0);

    // Saturate at strong taken, then one not-taken keeps prediction taken
    repeat (3) begin
      drive(1'b0, 1'b1, BEQ, 32'd7, 32'd7, 32'h100, 1'b1, 32'h100);
      tick();
    end
    drive(1'b0, 1'b1, BNE, 32'd7, 32'd7, 32'h100, 1'b1, 32'h100);
    check("bne_not_taken", 32'(token), 32'd0);
    tick();
    peek("sat_then_down", 32'h100, 1'b1);

    // Signed versus unsigned compares
    drive(1'b0, 1'b1, BLT, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    check("blt_signed", 32'(token), 32'd1);
    drive(1'b0, 1'b1, BLTU, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    check("bltu_unsigned", 32'(token), 32'd0);
    drive(1'b0, 1'b1, BGEU, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    check("bgeu_unsigned", 32'(token), 32'd1);
    tick();

    // Jumps resolve taken and never train
    do_reset();
    drive(1'b0, 1'b1, JALR, 32'd0, 32'd0, 32'h200, 1'b0, 32'h200);
    check("jalr_token", 32'(token), 32'd1);
    check("jalr_mispredict", 32'(mispredict), 32'd1);
    tick();
    peek("jalr_no_train", 32'h200, 1'b0);

    // Aliasing: 0x100 and 0x200 share index 0
    repeat (2) begin
      drive(1'b0, 1'b1, BGE, 32'd3, 32'd3, 32'h100, 1'b0, 32'h200);
      tick();
    end
    peek("alias_200", 32'h200, 1'b1);

    // Resolve in a reset cycle is discarded
    drive(1'b1, 1'b1, BNE, 32'd1, 32'd2, 32'h40, 1'b0, 32'h40);
    check("reset_cycle_token", 32'(token), 32'd1);
    tick();
    drive(1'b1, 1'b1, BNE, 32'd1, 32'd2, 32'h40, 1'b0, 32'h40);
    tick();
    reset = 1'b0;
    peek("reset_discard", 32'h40, 1'b0);

`ifdef BRANCH_PERF_CNT_EN
    // 5 conditional resolves (2 mispredicted) plus one mispredicted JAL
    do_reset();
    drive(1'b0, 1'b1, BEQ, 32'd1, 32'd1, 32'h0, 1'b1, 32'h0); tick();
    drive(1'b0, 1'b1, BNE, 32'd1, 32'd1, 32'h4, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, BLT, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, BGE, 32'd1, 32'd2, 32'hC, 1'b1, 32'h0); tick();
    drive(1'b0, 1'b1, BLTU, 32'd1, 32'd2, 32'h10, 1'b1, 32'h0); tick();
    drive(1'b0, 1'b1, JAL, 32'd0, 32'd0, 32'h14, 1'b0, 32'h0); tick();
    check("perf_branches_5", perf_branches, 32'd5);
    check("perf_mispredicts_3", perf_mispredicts, 32'd3);
    do_reset();
    check("perf_branches_clr", perf_branches, 32'd0);
    check("perf_mispredicts_clr", perf_mispredicts, 32'd0);
`endif

    // Randomized resolves against the model, with occasional resets
    for (int n = 0; n < 600; n++) begin
      rf = Type'($urandom_range(0, 9));
      ra = $urandom();
      if ($urandom_range(0, 3) == 0) ra = ra % 32'd8;
      rb = ($urandom_range(0, 2) == 0) ? ra : $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb % 32'd8;
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), rf, ra, rb,
            32'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 2047)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
